// File: rtl/scan_signature_checker_if.sv
// Bus between a scan test controller and the signature checker.
// The master drives the test stimulus; the slave returns the signature and status.
interface scan_signature_checker_if;
  logic       start;
  logic       scan_en;
  logic       scan_data;
  logic [7:0] golden;
  logic [7:0] signature;
  logic       busy;
  logic       done;
  logic       pass;

  modport master (
    output start, scan_en, scan_data, golden,
    input  signature, busy, done, pass
  );

  modport slave (
    input  start, scan_en, scan_data, golden,
    output signature, busy, done, pass
  );
endinterface

// File: rtl/scan_signature_checker.sv
// Compacts a serial scan response into an 8-bit signature over NUM_BITS
// enabled captures, then compares it against a golden value.
module scan_signature_checker #(
  parameter int         NUM_BITS = 16,
  parameter logic [7:0] SEED     = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  scan_signature_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [7:0] NUM_BITS_C = 8'(NUM_BITS);

  // Feedback taps 7,5,4,3 folded into the incoming scan bit.
  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic d);
    return {s[6:0], d ^ s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_e     state_q, state_d;
  logic [7:0] sig_q,   sig_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       pass_q,  pass_d;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic; busy/done/pass are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
          sig_d   = SEED;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (bus.scan_en) begin
          sig_d = sig_step(sig_q, bus.scan_data);
          cnt_d = cnt_inc;
          if (cnt_inc == NUM_BITS_C) begin
            state_d = CHECK;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      CHECK: begin
        pass_d  = (sig_q == bus.golden);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = COLLECT;
          sig_d   = SEED;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        sig_d   = SEED;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  assign bus.signature = sig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_scan_signature_checker.sv
// Directed bench: a 16-bit checker driven from a vector table plus corner-case
// sequences, and a 1-bit checker with a non-zero seed.
module tb_scan_signature_checker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  scan_signature_checker_if bus0();
  scan_signature_checker_if bus1();

  scan_signature_checker #(.NUM_BITS(16), .SEED(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  scan_signature_checker #(.NUM_BITS(1), .SEED(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] stream;   // bit 15 is shifted in first
    logic [7:0]  gold;
    logic [7:0]  exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] sig_hist [16];
  logic [7:0] sig_a, sig_b;
  logic       pass_a, pass_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full 16-bit test on dut0; start issued from IDLE or DONE.
  task automatic run_stream(input logic [15:0] stream, input logic [7:0] gold,
                            input int gap_pct, input bit mid_start,
                            output logic [7:0] sig_out, output logic pass_out);
    logic [7:0] held;
    int gaps;
    gaps = 0;
    @(negedge clk);
    bus0.start     = 1'b1;
    bus0.scan_en   = 1'b1;
    bus0.scan_data = 1'b1;
    bus0.golden    = gold;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("seed_load", {24'd0, bus0.signature}, 32'h00);
    chk("busy_after_start", {31'd0, bus0.busy}, 32'd1);
    chk("done_clear_after_start", {31'd0, bus0.done}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      held = bus0.signature;
      while (gaps < 64 && $urandom_range(0, 99) < gap_pct) begin
        bus0.scan_en   = 1'b0;
        bus0.scan_data = ~bus0.scan_data;
        @(negedge clk);
        gaps++;
        chk("hold_on_gap", {24'd0, bus0.signature}, {24'd0, held});
      end
      bus0.scan_en   = 1'b1;
      bus0.scan_data = stream[15-i];
      bus0.start     = mid_start && (i == 5);
      @(negedge clk);
      bus0.start  = 1'b0;
      sig_hist[i] = bus0.signature;
      if (i < 15) begin
        chk("busy_in_collect", {31'd0, bus0.busy}, 32'd1);
      end else begin
        chk("no_done_at_capture16", {31'd0, bus0.done}, 32'd0);
      end
    end
    bus0.scan_en = 1'b1;
    @(negedge clk);
    bus0.scan_en = 1'b0;
    chk("done_latency", {31'd0, bus0.done}, 32'd1);
    chk("busy_low_in_done", {31'd0, bus0.busy}, 32'd0);
    sig_out  = bus0.signature;
    pass_out = bus0.pass;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{16'h0000, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{16'h8000, 8'h25, 8'h25, 1'b1};
    vecs[2] = '{16'h8000, 8'h24, 8'h25, 1'b0};
    vecs[3] = '{16'h0001, 8'h01, 8'h01, 1'b1};
    vecs[4] = '{16'hC000, 8'h37, 8'h37, 1'b1};
    vecs[5] = '{16'h8001, 8'h25, 8'h24, 1'b0};

    rst_n          = 1'b0;
    bus0.start     = 1'b0;
    bus0.scan_en   = 1'b0;
    bus0.scan_data = 1'b0;
    bus0.golden    = 8'h00;
    bus1.start     = 1'b0;
    bus1.scan_en   = 1'b0;
    bus1.scan_data = 1'b0;
    bus1.golden    = 8'h4B;
    repeat (3) @(negedge clk);
    chk("reset_sig", {24'd0, bus0.signature}, 32'h00);
    chk("reset_busy_done_pass", {29'd0, bus0.busy, bus0.done, bus0.pass}, 32'd0);
    chk("reset_sig_seed_a5", {24'd0, bus1.signature}, 32'hA5);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {30'd0, bus0.busy, bus0.done}, 32'd0);

    // Single-bit checker: start with scan_en high only loads the seed.
    bus1.start     = 1'b1;
    bus1.scan_en   = 1'b1;
    bus1.scan_data = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("nb1_seed_only", {24'd0, bus1.signature}, 32'hA5);
    @(negedge clk);
    bus1.scan_en = 1'b0;
    chk("nb1_capture", {24'd0, bus1.signature}, 32'h4B);
    chk("nb1_no_done_yet", {31'd0, bus1.done}, 32'd0);
    @(negedge clk);
    chk("nb1_done", {31'd0, bus1.done}, 32'd1);
    chk("nb1_pass", {31'd0, bus1.pass}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      run_stream(vecs[v].stream, vecs[v].gold, 0, 1'b0, sig_a, pass_a);
      chk($sformatf("vec%0d_sig", v), {24'd0, sig_a}, {24'd0, vecs[v].exp_sig});
      chk($sformatf("vec%0d_pass", v), {31'd0, pass_a}, {31'd0, vecs[v].exp_pass});
    end

    run_stream(16'h8000, 8'h25, 0, 1'b0, sig_a, pass_a);
    chk("sig_after_bit1", {24'd0, sig_hist[0]}, 32'h01);
    chk("sig_after_bit5", {24'd0, sig_hist[4]}, 32'h11);
    chk("sig_after_bit8", {24'd0, sig_hist[7]}, 32'h8E);
    repeat (3) @(negedge clk);
    chk("done_hold", {30'd0, bus0.done, bus0.pass}, 32'd3);
    chk("sig_hold", {24'd0, bus0.signature}, 32'h25);

    run_stream(16'h8000, 8'h25, 30, 1'b0, sig_a, pass_a);
    chk("gappy_sig", {24'd0, sig_a}, 32'h25);
    chk("gappy_pass", {31'd0, pass_a}, 32'd1);

    run_stream(16'h8000, 8'h25, 0, 1'b1, sig_a, pass_a);
    chk("mid_start_sig", {24'd0, sig_a}, 32'h25);
    chk("mid_start_pass", {31'd0, pass_a}, 32'd1);

    // Back-to-back tests straight out of DONE.
    run_stream(16'hC000, 8'h37, 0, 1'b0, sig_a, pass_a);
    run_stream(16'hC000, 8'h37, 0, 1'b0, sig_b, pass_b);
    chk("b2b_sig", {24'd0, sig_b}, {24'd0, sig_a});
    chk("b2b_pass", {31'd0, pass_b}, 32'd1);

    // Abort mid-collect with an asynchronous reset.
    @(negedge clk);
    bus0.start     = 1'b1;
    bus0.scan_en   = 1'b0;
    bus0.golden    = 8'h25;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus0.scan_en   = 1'b1;
      bus0.scan_data = (i == 0);
      @(negedge clk);
    end
    bus0.scan_en = 1'b0;
    chk("pre_reset_sig", {24'd0, bus0.signature}, 32'h8E);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sig", {24'd0, bus0.signature}, 32'h00);
    chk("async_reset_flags", {29'd0, bus0.busy, bus0.done, bus0.pass}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_abort", {30'd0, bus0.busy, bus0.done}, 32'd0);
    run_stream(16'h8000, 8'h25, 0, 1'b0, sig_a, pass_a);
    chk("post_reset_sig", {24'd0, sig_a}, 32'h25);
    chk("post_reset_pass", {31'd0, pass_a}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
